// File: rtl/rx_frame_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_buffer_if
//  Description : Rx datapath capture signals plus the show-ahead valid/ready
//                read port of rx_frame_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rx_frame_buffer_if #(
    parameter int DATA_SIZE = 8
);
    // Rx datapath side
    logic                 frame_done;
    logic [DATA_SIZE-1:0] Rx_out;
    logic                 trans_error;
    logic                 data_error;
    // Host read port
    logic                 rd_ready;
    logic                 rd_valid;
    logic [DATA_SIZE-1:0] rd_data;
    logic                 rd_trans_err;
    logic                 rd_data_err;

    // Environment: Rx datapath and host
    modport master (
        output frame_done, Rx_out, trans_error, data_error, rd_ready,
        input  rd_valid, rd_data, rd_trans_err, rd_data_err
    );

    // Frame buffer
    modport slave (
        input  frame_done, Rx_out, trans_error, data_error, rd_ready,
        output rd_valid, rd_data, rd_trans_err, rd_data_err
    );
endinterface
`default_nettype wire

// File: rtl/rx_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_buffer
//  Description : Captures each completed Rx frame (rising edge of frame_done)
//                into a circular FIFO and presents it on a show-ahead
//                valid/ready port. Tracks occupancy and a sticky overflow.
//                Optional macro RX_BUF_DROP_ERR_EN discards errored frames
//                and counts them in drop_cnt instead of storing them.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_buffer #(
    parameter int DATA_SIZE  = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int PARITY_ON  = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    rx_frame_buffer_if.slave           bus,
    input  wire logic                  clr_ovf,
    output logic [ADDR_WIDTH:0]        count,
    output logic                       full,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam logic                c_PAR_EN = (PARITY_ON != 0);
    localparam logic [ADDR_WIDTH:0] c_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
`ifdef RX_BUF_DROP_ERR_EN
    // Errored frames are never stored, so only the data word is kept
    localparam int                  c_ENTRY_W = DATA_SIZE;
`else
    localparam int                  c_ENTRY_W = DATA_SIZE + 2;
`endif

    logic [c_ENTRY_W-1:0]  r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_frame_done_q;

    logic                  w_cap;
    logic                  w_store;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_ovf_set;
    logic [c_ENTRY_W-1:0]  w_wr_entry;
    logic [c_ENTRY_W-1:0]  w_head;

    assign w_cap  = bus.frame_done & ~r_frame_done_q;
    assign full   = (r_count == c_DEPTH);
    assign w_pop  = bus.rd_valid & bus.rd_ready;

`ifdef RX_BUF_DROP_ERR_EN
    logic       w_err;
    logic [7:0] r_drop_cnt;

    assign w_err      = bus.trans_error | (c_PAR_EN & bus.data_error);
    assign w_store    = w_cap & ~w_err;
    assign w_wr_entry = bus.Rx_out;

    // Saturating count of errored frames discarded at capture
    always_ff @(posedge clk) begin
        if (!rst)
            r_drop_cnt <= 8'd0;
        else if (w_cap && w_err && r_drop_cnt != 8'hFF)
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_cnt         = r_drop_cnt;
    assign bus.rd_data      = w_head;
    assign bus.rd_trans_err = 1'b0;
    assign bus.rd_data_err  = 1'b0;
`else
    assign w_store          = w_cap;
    assign w_wr_entry       = {bus.data_error & c_PAR_EN, bus.trans_error, bus.Rx_out};
    assign drop_cnt         = 8'd0;
    assign bus.rd_data      = w_head[DATA_SIZE-1:0];
    assign bus.rd_trans_err = w_head[DATA_SIZE];
    assign bus.rd_data_err  = w_head[DATA_SIZE+1];
`endif

    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_push    = w_store & (~full | w_pop);
    assign w_ovf_set = w_store & full & ~w_pop;

    // Show-ahead head: asynchronous read of the entry at rd_ptr
    assign w_head       = r_mem[r_rd_ptr];
    assign bus.rd_valid = (r_count != '0);
    assign count        = r_count;
    assign overflow     = r_overflow;

    // Edge detector; reset to 1 so a flag held through reset is not captured
    always_ff @(posedge clk) begin
        if (!rst)
            r_frame_done_q <= 1'b1;
        else
            r_frame_done_q <= bus.frame_done;
    end

    // Storage array, written without reset (contents are don't-care when empty)
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_wr_entry;
    end

    // Pointers and occupancy; pointers wrap through natural overflow
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    // Sticky overflow; a set in the same cycle as clr_ovf takes priority
    always_ff @(posedge clk) begin
        if (!rst)
            r_overflow <= 1'b0;
        else if (w_ovf_set)
            r_overflow <= 1'b1;
        else if (clr_ovf)
            r_overflow <= 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_frame_buffer
//  Description : Self-checking bench for rx_frame_buffer. Two instances
//                (parity on / parity off) share one stimulus stream and are
//                compared every cycle against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_buffer;

    localparam int DS    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus
    logic          fd      = 1'b0;
    logic [DS-1:0] rx      = '0;
    logic          te      = 1'b0;
    logic          de      = 1'b0;
    logic          rdy     = 1'b0;
    logic          clr_ovf = 1'b0;

    rx_frame_buffer_if #(.DATA_SIZE(DS)) bus_a ();
    rx_frame_buffer_if #(.DATA_SIZE(DS)) bus_b ();

    assign bus_a.frame_done  = fd;
    assign bus_a.Rx_out      = rx;
    assign bus_a.trans_error = te;
    assign bus_a.data_error  = de;
    assign bus_a.rd_ready    = rdy;
    assign bus_b.frame_done  = fd;
    assign bus_b.Rx_out      = rx;
    assign bus_b.trans_error = te;
    assign bus_b.data_error  = de;
    assign bus_b.rd_ready    = rdy;

    logic [AW:0] count_a, count_b;
    logic        full_a, full_b, ovf_a, ovf_b;
    logic [7:0]  drop_a, drop_b;

    rx_frame_buffer #(.DATA_SIZE(DS), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .PARITY_ON(1)) dut (
        .clk(clk), .rst(rst), .bus(bus_a), .clr_ovf(clr_ovf),
        .count(count_a), .full(full_a), .overflow(ovf_a), .drop_cnt(drop_a)
    );

    rx_frame_buffer #(.DATA_SIZE(DS), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .PARITY_ON(0)) dut_np (
        .clk(clk), .rst(rst), .bus(bus_b), .clr_ovf(clr_ovf),
        .count(count_b), .full(full_b), .overflow(ovf_b), .drop_cnt(drop_b)
    );

    // Reference model: queue of raw frames {data_error, trans_error, data}
    logic [DS+1:0] q[$];
    bit            m_prev_fd = 1'b1;
    bit            m_ovf     = 1'b0;
    int            m_drop    = 0;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the frame-buffer rules to the inputs seen at this clock edge
    task automatic model_update();
        bit cap, pop, full_before, err, ovf_set;
        cap       = fd && !m_prev_fd;
        m_prev_fd = fd;
        if (!rst) begin
            q.delete();
            m_prev_fd = 1'b1;
            m_ovf     = 1'b0;
            m_drop    = 0;
            return;
        end
        full_before = (q.size() == DEPTH);
        pop         = (q.size() != 0) && rdy;
        ovf_set     = 1'b0;
        if (pop) void'(q.pop_front());
`ifdef RX_BUF_DROP_ERR_EN
        err = te || de;
`else
        err = 1'b0;
`endif
        if (cap) begin
            if (err) begin
                if (m_drop < 255) m_drop++;
            end else if (!full_before || pop) begin
                q.push_back({de, te, rx});
            end else begin
                ovf_set = 1'b1;
            end
        end
        if (ovf_set)      m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
    endtask

    task automatic check_all();
        bit ne;
        ne = (q.size() != 0);
        chk("rd_valid", 32'(bus_a.rd_valid), 32'(ne));
        chk("count",    32'(count_a),        32'(q.size()));
        chk("full",     32'(full_a),         32'(q.size() == DEPTH));
        chk("overflow", 32'(ovf_a),          32'(m_ovf));
        chk("drop_cnt", 32'(drop_a),         32'(m_drop));
        if (ne) begin
            chk("rd_data", 32'(bus_a.rd_data), 32'(q[0][DS-1:0]));
`ifdef RX_BUF_DROP_ERR_EN
            chk("rd_trans_err", 32'(bus_a.rd_trans_err), 32'h0);
            chk("rd_data_err",  32'(bus_a.rd_data_err),  32'h0);
`else
            chk("rd_trans_err", 32'(bus_a.rd_trans_err), 32'(q[0][DS]));
            chk("rd_data_err",  32'(bus_a.rd_data_err),  32'(q[0][DS+1]));
`endif
        end
`ifndef RX_BUF_DROP_ERR_EN
        // Parity-off instance holds the same frames with the parity bit masked
        chk("np_count",    32'(count_b),        32'(q.size()));
        chk("np_rd_valid", 32'(bus_b.rd_valid), 32'(ne));
        chk("np_overflow", 32'(ovf_b),          32'(m_ovf));
        chk("np_drop_cnt", 32'(drop_b),         32'h0);
        if (ne) begin
            chk("np_rd_data",      32'(bus_b.rd_data),      32'(q[0][DS-1:0]));
            chk("np_rd_trans_err", 32'(bus_b.rd_trans_err), 32'(q[0][DS]));
            chk("np_rd_data_err",  32'(bus_b.rd_data_err),  32'h0);
        end
`endif
    endtask

    // One clock: model sees the edge, outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic send_frame(input logic [DS-1:0] d, input logic t, input logic e, input int hold);
        rx = d; te = t; de = e; fd = 1'b1;
        repeat (hold) tick();
        fd = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Single frame held 5 cycles -> exactly one entry
        rx = 8'hA5; te = 1'b0; de = 1'b0; fd = 1'b1;
        tick();
        chk("single_count", 32'(count_a), 32'd1);
        chk("single_data",  32'(bus_a.rd_data), 32'hA5);
        repeat (4) tick();
        fd = 1'b0;
        tick();
        chk("single_hold_count", 32'(count_a), 32'd1);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("single_pop_valid", 32'(bus_a.rd_valid), 32'd0);
        tick();

        // Fill to full, pop 3, push 3 more across the wrap, then drain
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0, 1);
        chk("fill_full", 32'(full_a), 32'd1);
        rdy = 1'b1;
        repeat (3) tick();
        rdy = 1'b0;
        chk("after_pop3_head", 32'(bus_a.rd_data), 32'h04);
        for (int i = 9; i <= 11; i++) send_frame(8'(i), 1'b0, 1'b0, 2);
        rdy = 1'b1;
        repeat (10) tick();
        rdy = 1'b0;

        // Overflow: full FIFO, frame with no read -> dropped, sticky flag
        for (int i = 0; i < 8; i++) send_frame(8'($urandom), 1'b0, 1'b0, 1);
        send_frame(8'hFF, 1'b0, 1'b0, 3);
        chk("ovf_set", 32'(ovf_a), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(ovf_a), 32'd0);
        // Frame while full with a pop in the capture cycle -> accepted
        rx = 8'h5A; fd = 1'b1; rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("full_pop_count", 32'(count_a), 32'd8);
        tick();
        fd = 1'b0;
        tick();
        // Set and clear in the same cycle: set wins
        rx = 8'h66; fd = 1'b1; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0; fd = 1'b0;
        chk("ovf_set_wins", 32'(ovf_a), 32'd1);
        tick();
        rdy = 1'b1;
        repeat (9) tick();
        rdy = 1'b0;
        tick();

        // Error flags
        send_frame(8'h3C, 1'b1, 1'b1, 2);
        send_frame(8'h3C, 1'b0, 1'b1, 2);
        send_frame(8'h3C, 1'b1, 1'b0, 2);
        rdy = 1'b1;
        repeat (4) tick();
        rdy = 1'b0;

        // Saturation of the drop counter (macro build) / plain storage otherwise
        for (int i = 0; i < 300; i++) send_frame(8'($urandom), 1'b1, 1'(i & 1), 1);
        rdy = 1'b1;
        repeat (9) tick();
        rdy = 1'b0;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;

        // Reset with entries stored and frame_done held through it
        for (int i = 0; i < 4; i++) send_frame(8'(8'h40 + i), 1'b0, 1'b0, 1);
        fd = 1'b1; rx = 8'h77;
        rst = 1'b0;
        repeat (2) tick();
        chk("rst_count", 32'(count_a), 32'd0);
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_no_capture", 32'(bus_a.rd_valid), 32'd0);
        fd = 1'b0;
        tick();
        fd = 1'b1;
        tick();
        chk("rst_recapture", 32'(count_a), 32'd1);
        fd = 1'b0;
        tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (fd) fd = ($urandom_range(0, 3) != 0);
            else begin
                fd = ($urandom_range(0, 2) == 0);
                rx = 8'($urandom);
                te = ($urandom_range(0, 4) == 0);
                de = ($urandom_range(0, 4) == 0);
            end
            rdy     = ($urandom_range(0, 2) == 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst = 1'b1; fd = 1'b0; rdy = 1'b0; clr_ovf = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
